// File: rtl/psa_pkg.sv
// Shared types and default sizing for the chunk-serial adder.
// Optional subtract mode in the top is enabled with macro PSA_SUB_EN.
package psa_pkg;

  localparam int PSA_WIDTH = 8;
  localparam int PSA_CHUNK = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } psa_state_e;

endpackage

// File: rtl/param_serial_adder_chunk.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells.
// c_msb_in is the carry into the top bit, used for signed overflow.
module chunk_adder #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co       = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/param_serial_adder.sv
// Chunk-serial adder: WIDTH-bit add, CHUNK bits per cycle, LSB chunk first.
// Define PSA_SUB_EN to add a 'sub' input selecting a - b - cin.
module param_serial_adder
  import psa_pkg::*;
#(
  parameter int WIDTH = PSA_WIDTH,
  parameter int CHUNK = PSA_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PSA_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHK = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCH = WIDTH / CHK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  if (CHUNK < 1 || (WIDTH % CHK) != 0) begin : g_bad_cfg
    $error("param_serial_adder: CHUNK must be >=1 and divide WIDTH");
  end

  psa_state_e       st;
  logic [WIDTH-1:0] ar, br, acc, nxt_acc;
  logic [KW-1:0]    k;
  logic             cr;
  logic [CHK-1:0]   ca, cb, cs;
  logic             co, cmsb;
  logic             last;

  assign ca   = ar[int'(k)*CHK +: CHK];
  assign cb   = br[int'(k)*CHK +: CHK];
  assign last = (k == KW'(NCH-1));

  chunk_adder #(.CHUNK(CHK)) u_chunk (
    .a        (ca),
    .b        (cb),
    .ci       (cr),
    .s        (cs),
    .co       (co),
    .c_msb_in (cmsb)
  );

  // Merge the current chunk into the partial result so the final chunk
  // can go straight to the sum register on entry to DONE.
  always_comb begin
    nxt_acc = acc;
    nxt_acc[int'(k)*CHK +: CHK] = cs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= ST_IDLE;
      ar   <= '0;
      br   <= '0;
      acc  <= '0;
      k    <= '0;
      cr   <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      case (st)
        ST_RUN: begin
          acc <= nxt_acc;
          cr  <= co;
          k   <= k + 1'b1;
          if (last) begin
            st   <= ST_DONE;
            busy <= 1'b0;
            done <= 1'b1;
            sum  <= nxt_acc;
            cout <= co;
            ovf  <= co ^ cmsb;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request
          done <= 1'b0;
          if (start) begin
            st   <= ST_RUN;
            busy <= 1'b1;
            ar   <= a;
            k    <= '0;
`ifdef PSA_SUB_EN
            // a - b - cin == a + ~b + ~cin
            br   <= sub ? ~b : b;
            cr   <= sub ? ~cin : cin;
`else
            br   <= b;
            cr   <= cin;
`endif
          end else begin
            st   <= ST_IDLE;
            busy <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_serial_adder.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops
// and checks on each done pulse. Covers WIDTH=8/CHUNK=2 and WIDTH=2/CHUNK=1.
module tb_param_serial_adder;

  localparam int NCH8 = 4;
  localparam int NCH2 = 2;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  logic       start2 = 1'b0, cin2 = 1'b0, sub2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] sum2;

  exp_t q8[$];
  exp_t q2[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic [7:0] held8 = '0;
  bit   fin = 1'b0;
  bit   fin_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  param_serial_adder #(.WIDTH(8), .CHUNK(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef PSA_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  param_serial_adder #(.WIDTH(2), .CHUNK(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
`ifdef PSA_SUB_EN
    .sub(sub2),
`endif
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_sum8", int'(sum8), 0);
      chk("rst_cout8", int'(cout8), 0);
      chk("rst_ovf8", int'(ovf8), 0);
      chk("rst_busy8", int'(busy8), 0);
      chk("rst_done8", int'(done8), 0);
      chk("rst_sum2", int'(sum2), 0);
      chk("rst_done2", int'(done2), 0);
      q8.delete();
      q2.delete();
      held8 = '0;
    end else begin
      if (done8) begin
        if (q8.size() == 0) chk("spurious_done8", 1, 0);
        else begin
          e = q8.pop_front();
          chk("sum8", int'(sum8), int'(e.sum));
          chk("cout8", int'(cout8), int'(e.cout));
          chk("ovf8", int'(ovf8), int'(e.ovf));
          chk("lat8", cyc, e.cyc);
          chk("busy_in_done8", int'(busy8), 0);
          held8 = e.sum;
        end
      end else if (busy8) begin
        chk("hold8", int'(sum8), int'(held8));
      end
      if (done2) begin
        if (q2.size() == 0) chk("spurious_done2", 1, 0);
        else begin
          e = q2.pop_front();
          chk("sum2", int'(sum2), int'(e.sum[1:0]));
          chk("cout2", int'(cout2), int'(e.cout));
          chk("ovf2", int'(ovf2), int'(e.ovf));
          chk("lat2", cyc, e.cyc);
        end
      end
      if (fin && !fin_done) begin
        chk("pending8", q8.size(), 0);
        chk("pending2", q2.size(), 0);
        fin_done = 1'b1;
      end
    end
  end

  task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                        input logic sb, input logic [7:0] es, input logic ec,
                        input logic eo);
    exp_t e;
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = ci; sub8 = sb; start8 = 1'b1;
    e.sum = es; e.cout = ec; e.ovf = eo; e.cyc = cyc + NCH8 + 1;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                     input logic sb, input logic [7:0] es, input logic ec,
                     input logic eo);
    issue8(av, bv, ci, sb, es, ec, eo);
    repeat (NCH8) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;

    op8(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    op8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op8(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    op8(8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    op8(8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

    // start pulsed mid-RUN with new operands must be ignored
    issue8(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h5A;
    repeat (6) @(negedge clk);

    // reset mid-RUN aborts with no done
    issue8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    op8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);

`ifdef PSA_SUB_EN
    op8(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    op8(8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
`endif

    // all 32 combinations back-to-back on the 2-bit instance
    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      int sa, sb, s;
      v = i[4:0];
      @(negedge clk);
      a2 = v[4:3]; b2 = v[2:1]; cin2 = v[0]; start2 = 1'b1;
      sa = v[4] ? int'(v[4:3]) - 4 : int'(v[4:3]);
      sb = v[2] ? int'(v[2:1]) - 4 : int'(v[2:1]);
      s  = sa + sb + int'(v[0]);
      e.sum  = 8'((int'(v[4:3]) + int'(v[2:1]) + int'(v[0])) % 4);
      e.cout = (int'(v[4:3]) + int'(v[2:1]) + int'(v[0])) > 3;
      e.ovf  = (s > 1) || (s < -2);
      e.cyc  = cyc + NCH2 + 1;
      q2.push_back(e);
      @(negedge clk);
      start2 = 1'b0;
      @(negedge clk);
    end
    repeat (8) @(negedge clk);

    fin = 1'b1;
    for (int i = 0; i < 10 && !fin_done; i++) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_serial_adder.md
PARAM_SERIAL_ADDER -- requirements
Module: param_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 2, bits added per cycle; WIDTH%CHUNK==0 and CHUNK>=1, otherwise elaboration SHALL fail.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request a new addition.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port cin  input  1  carry-in.
REQ-009 SHALL have port busy  output  1  operation in progress; start ignored.
REQ-010 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port sum  output  WIDTH  result.
REQ-012 SHALL have port cout  output  1  carry-out of the MSB.
REQ-013 SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; NCH = WIDTH/CHUNK.
REQ-015 IDLE or DONE with start=1: capture a, b, cin, clear chunk index, go to RUN next cycle.
REQ-016 RUN: add chunk k (LSB first) of the captured operands plus the carry register, store CHUNK result bits, update the carry register, increment k.
REQ-017 RUN with k==NCH-1: go to DONE next cycle.
REQ-018 DONE lasts one cycle, then IDLE unless start=1 (REQ-015).
REQ-019 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-020 Latency: start sampled at edge t, done=1 in the cycle after edge t+NCH+1, i.e. NCH+1 cycles.
REQ-021 sum, cout and ovf SHALL update only on entry to DONE and hold until the next entry to DONE, including during a following RUN.
REQ-022 ovf = carry into MSB XOR carry out of MSB.
REQ-023 start while busy=1 SHALL be ignored; it causes no capture and no state change.
REQ-024 Input changes after capture SHALL NOT affect the result in progress.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH; cout SHALL carry the (WIDTH+1)th bit.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, and clear the carry register and chunk index.
REQ-027 Reset mid-RUN SHALL abort the operation with no done pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-028 Macro PSA_SUB_EN: when defined, add port sub  input  1, captured with the operands.
REQ-029 With PSA_SUB_EN and sub=1: compute a - b - cin as a + ~b + ~cin; cout=1 means no borrow; ovf per REQ-022.
REQ-030 Without PSA_SUB_EN: no sub port; addition only.

Structure
REQ-031 Package psa_pkg SHALL hold the FSM state typedef and the default WIDTH/CHUNK constants.
REQ-032 Sub-module chunk_adder SHALL hold a combinational CHUNK-bit ripple adder built from full-adder cells (a, b, ci -> s, co, c_msb_in); it is instantiated once.

Verification
REQ-033 WIDTH=8, CHUNK=2; start with a=0x0F, b=0x01, cin=0 -> done 5 cycles later, sum=0x10, cout=0, ovf=0.
REQ-034 a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1, ovf=0; a=0x7F, b=0x01, cin=0 -> sum=0x80, ovf=1.
REQ-035 Pulse start again 2 cycles into RUN with different operands -> ignored, single done, original result; sum of the prior op stays stable throughout RUN.
REQ-036 rst_n low mid-RUN -> outputs zero immediately, no done pulse; next op correct.
REQ-037 WIDTH=2, CHUNK=1: all 32 {a, b, cin} combinations, back-to-back starts in DONE -> each result equals a+b+cin, with done every 3 cycles.
REQ-038 PSA_SUB_EN defined, sub=1, a=0x05, b=0x07, cin=0 -> sum=0xFE, cout=0, ovf=0.
